// File: rtl/epsilon_greedy_pkg.sv
// Shared types and defaults for the epsilon-greedy action selector.
package epsilon_greedy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECIDE = 2'd1,
    OUT    = 2'd2
  } state_e;

  // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [31:0] LFSR_SEED_DEF = 32'hACE1_2468;
  localparam logic [15:0] EPS_INIT_DEF  = 16'hFFFF;
  localparam logic [15:0] EPS_DECAY_DEF = 16'hFF3B;
  localparam logic [15:0] EPS_MIN_DEF   = 16'h028F;

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR that steps only when asked, so a model can track it exactly.
module lfsr32_galois
  import epsilon_greedy_pkg::*;
#(
  parameter logic [31:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_advance,
  output logic [31:0] o_state
);

  // An all-zero state would lock up the register
  localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (i_advance)
      state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_TAPS : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEED_NZ;
    else        state_q <= state_d;
  end

  assign o_state = state_q;

endmodule

// File: rtl/epsilon_greedy_fx.sv
// Epsilon-greedy action selector: swaps the greedy action for a uniform random
// one with probability epsilon in train mode; epsilon decays and is loadable.
module epsilon_greedy_fx
  import epsilon_greedy_pkg::*;
#(
  parameter int                    NUM_ACTIONS  = 3,
  parameter int                    ACTION_WIDTH = 2,
  parameter int                    EPS_WIDTH    = 16,
  parameter logic [EPS_WIDTH-1:0]  EPS_INIT     = EPS_INIT_DEF,
  parameter logic [EPS_WIDTH-1:0]  EPS_DECAY    = EPS_DECAY_DEF,
  parameter logic [EPS_WIDTH-1:0]  EPS_MIN      = EPS_MIN_DEF,
  parameter logic [31:0]           LFSR_SEED    = LFSR_SEED_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [ACTION_WIDTH-1:0] i_action_predict,
  input  logic                    i_train_mode,
  input  logic                    i_decay,
  input  logic                    i_eps_load,
  input  logic [EPS_WIDTH-1:0]    i_eps_value,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [ACTION_WIDTH-1:0] o_action,
  output logic                    o_explored,
  output logic [EPS_WIDTH-1:0]    o_epsilon
);

  localparam logic [ACTION_WIDTH-1:0] MAX_ACT = ACTION_WIDTH'(NUM_ACTIONS - 1);
  localparam int                      RW      = 16 + ACTION_WIDTH;

  state_e                  state_q;
  logic [ACTION_WIDTH-1:0] pred_q, action_q;
  logic                    train_q, explored_q, valid_q;
  logic [EPS_WIDTH-1:0]    eps_q, eps_d;
  logic [31:0]             r;

  wire accept = (state_q == IDLE) && i_valid;

  lfsr32_galois #(.SEED(LFSR_SEED)) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_advance (accept),
    .o_state   (r)
  );

  // Multiply-shift maps the top 16 random bits onto 0..NUM_ACTIONS-1 directly
  logic [RW-1:0]           rnd_prod;
  logic [ACTION_WIDTH-1:0] rnd_act, pred_clamped;
  logic                    explore;

  assign rnd_prod     = RW'(r[31:16]) * RW'(NUM_ACTIONS);
  assign rnd_act      = ACTION_WIDTH'(rnd_prod >> 16);
  assign pred_clamped = (pred_q > MAX_ACT) ? MAX_ACT : pred_q;
  assign explore      = train_q && (r[EPS_WIDTH-1:0] < eps_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pred_q     <= '0;
      train_q    <= 1'b0;
      action_q   <= '0;
      explored_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          pred_q  <= i_action_predict;
          train_q <= i_train_mode;
          state_q <= DECIDE;
        end
        DECIDE: begin
          action_q   <= explore ? rnd_act : pred_clamped;
          explored_q <= explore;
          valid_q    <= 1'b1;
          state_q    <= OUT;
        end
        OUT: if (o_ready) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Load has priority over decay; decay result never falls below EPS_MIN
  logic [2*EPS_WIDTH-1:0] dprod;
  logic [EPS_WIDTH-1:0]   p;

  assign dprod = {{EPS_WIDTH{1'b0}}, eps_q} * {{EPS_WIDTH{1'b0}}, EPS_DECAY};
  assign p     = EPS_WIDTH'(dprod >> EPS_WIDTH);

  always_comb begin
    eps_d = eps_q;
    if (i_eps_load)   eps_d = i_eps_value;
    else if (i_decay) eps_d = (p < EPS_MIN) ? EPS_MIN : p;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) eps_q <= EPS_INIT;
    else        eps_q <= eps_d;
  end

  assign i_ready    = (state_q == IDLE);
  assign o_valid    = valid_q;
  assign o_action   = action_q;
  assign o_explored = explored_q;
  assign o_epsilon  = eps_q;

endmodule

// File: tb/tb_epsilon_greedy_fx.sv
// Directed bench for epsilon_greedy_fx with an independent LFSR/epsilon model.
module tb_epsilon_greedy_fx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0, i_ready;
  logic [1:0]  i_action_predict = '0;
  logic        i_train_mode = 1'b0, i_decay = 1'b0, i_eps_load = 1'b0;
  logic [15:0] i_eps_value = '0;
  logic        o_valid, o_ready = 1'b1, o_explored;
  logic [1:0]  o_action;
  logic [15:0] o_epsilon;

  epsilon_greedy_fx dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
    .i_action_predict(i_action_predict), .i_train_mode(i_train_mode),
    .i_decay(i_decay), .i_eps_load(i_eps_load), .i_eps_value(i_eps_value),
    .o_valid(o_valid), .o_ready(o_ready), .o_action(o_action),
    .o_explored(o_explored), .o_epsilon(o_epsilon)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0, bad = 0;
  logic [31:0] m_lfsr = 32'hACE1_2468;
  logic [15:0] m_eps  = 16'hFFFF;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  // Advance the model once and predict the outcome of a request
  task automatic model_req(input logic [1:0] pred, input logic tr,
                           output logic [1:0] eact, output logic eex);
    logic [17:0] pp;
    m_lfsr = step(m_lfsr);
    eex    = tr && (m_lfsr[15:0] < m_eps);
    pp     = {2'b00, m_lfsr[31:16]} * 18'd3;
    eact   = eex ? pp[17:16] : ((pred > 2'd2) ? 2'd2 : pred);
  endtask

  // Full handshake with o_ready=1; returns what the DUT produced
  task automatic dut_req(input logic [1:0] pred, input logic tr,
                         output logic [1:0] act, output logic ex);
    int n;
    @(negedge clk);
    i_action_predict = pred; i_train_mode = tr; i_valid = 1'b1; o_ready = 1'b1;
    n = 0;
    while (!i_ready && n < 10) begin @(negedge clk); n++; end
    if (n == 10) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 10) begin @(negedge clk); n++; end
    if (n == 10) chk("valid_timeout", 32'd0, 32'd1);
    act = o_action; ex = o_explored;
    @(posedge clk);
  endtask

  task automatic req_check(input string nm, input logic [1:0] pred, input logic tr);
    logic [1:0] a, ea; logic e, ee;
    dut_req(pred, tr, a, e);
    model_req(pred, tr, ea, ee);
    chk({nm, "_action"}, {30'd0, a}, {30'd0, ea});
    chk({nm, "_explored"}, {31'd0, e}, {31'd0, ee});
  endtask

  task automatic eps_op(input logic ld, input logic dc, input logic [15:0] v,
                        input logic [15:0] exp, input string nm);
    @(negedge clk);
    i_eps_load = ld; i_decay = dc; i_eps_value = v;
    @(negedge clk);
    i_eps_load = 1'b0; i_decay = 1'b0;
    m_eps = exp;
    chk(nm, {16'd0, o_epsilon}, {16'd0, exp});
  endtask

  typedef struct { logic train; logic [1:0] pred; logic [1:0] exp_act; } vec_t;
  vec_t tbl[8];

  int         hist[3];
  int         mism, oor;
  logic [1:0] a, ea, hold_a;
  logic       e, ee, hold_e;

  initial begin
    tbl[0] = '{1'b0, 2'd0, 2'd0};
    tbl[1] = '{1'b0, 2'd1, 2'd1};
    tbl[2] = '{1'b0, 2'd2, 2'd2};
    tbl[3] = '{1'b0, 2'd3, 2'd2};
    tbl[4] = '{1'b1, 2'd0, 2'd0};
    tbl[5] = '{1'b1, 2'd1, 2'd1};
    tbl[6] = '{1'b1, 2'd2, 2'd2};
    tbl[7] = '{1'b1, 2'd3, 2'd2};

    // Reset state
    #12;
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_action", {30'd0, o_action}, 32'd0);
    chk("rst_o_explored", {31'd0, o_explored}, 32'd0);
    chk("rst_o_epsilon", {16'd0, o_epsilon}, 32'h0000_FFFF);
    chk("rst_i_ready", {31'd0, i_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // First-request latency, greedy mode
    @(negedge clk);
    i_action_predict = 2'd2; i_train_mode = 1'b0; i_valid = 1'b1; o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); i_valid = 1'b0;
    chk("lat_decide_valid", {31'd0, o_valid}, 32'd0);
    chk("lat_decide_ready", {31'd0, i_ready}, 32'd0);
    @(negedge clk);
    chk("lat_out_valid", {31'd0, o_valid}, 32'd1);
    chk("lat_out_action", {30'd0, o_action}, 32'd2);
    chk("lat_out_explored", {31'd0, o_explored}, 32'd0);
    @(negedge clk);
    chk("lat_back_ready", {31'd0, i_ready}, 32'd1);
    chk("lat_back_valid", {31'd0, o_valid}, 32'd0);
    m_lfsr = step(m_lfsr);

    // Epsilon decay, clamp, load-over-decay
    eps_op(1'b0, 1'b1, 16'h0000, 16'hFF3A, "decay_from_init");
    eps_op(1'b1, 1'b0, 16'h0290, 16'h0290, "load_0290");
    eps_op(1'b0, 1'b1, 16'h0000, 16'h028F, "decay_clamp");
    eps_op(1'b0, 1'b1, 16'h0000, 16'h028F, "decay_at_floor");
    eps_op(1'b1, 1'b1, 16'h1234, 16'h1234, "load_beats_decay");
    eps_op(1'b1, 1'b0, 16'h0001, 16'h0001, "load_below_min");
    eps_op(1'b0, 1'b1, 16'h0000, 16'h028F, "decay_below_min");

    // Epsilon 0: train mode must stay greedy
    eps_op(1'b1, 1'b0, 16'h0000, 16'h0000, "load_zero");
    for (int i = 0; i < 8; i++) begin
      dut_req(tbl[i].pred, tbl[i].train, a, e);
      model_req(tbl[i].pred, tbl[i].train, ea, ee);
      chk($sformatf("tbl%0d_action", i), {30'd0, a}, {30'd0, tbl[i].exp_act});
      chk($sformatf("tbl%0d_explored", i), {31'd0, e}, 32'd0);
    end
    mism = 0;
    for (int i = 0; i < 20; i++) begin
      logic [1:0] pr;
      pr = 2'($urandom_range(0, 2));
      dut_req(pr, 1'b1, a, e);
      model_req(pr, 1'b1, ea, ee);
      if (a !== pr || e !== 1'b0) mism++;
    end
    chk("greedy20_mismatches", mism, 32'd0);

    // Epsilon ~1.0: explores almost always; also proves LFSR step count so far
    eps_op(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, "load_ffff");
    req_check("after20", 2'd1, 1'b1);
    mism = 0; oor = 0;
    for (int i = 0; i < 3; i++) hist[i] = 0;
    for (int i = 0; i < 1000; i++) begin
      dut_req(2'd0, 1'b1, a, e);
      model_req(2'd0, 1'b1, ea, ee);
      if (a !== ea || e !== ee) begin
        if (mism == 0) $display("first divergence at %0d: act=%0d/%0d expl=%0d/%0d", i, a, ea, e, ee);
        mism++;
      end
      if (a > 2'd2) oor++;
      else hist[a]++;
    end
    chk("explore1000_mismatches", mism, 32'd0);
    chk("explore1000_out_of_range", oor, 32'd0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("hist%0d_in_band(count=%0d)", i, hist[i]),
          {31'd0, (hist[i] >= 273 && hist[i] <= 393)}, 32'd1);

    // Backpressure: hold OUT for 5 cycles, ignore i_valid meanwhile
    @(negedge clk);
    i_action_predict = 2'd1; i_train_mode = 1'b1; i_valid = 1'b1; o_ready = 1'b0;
    @(posedge clk);
    @(negedge clk); i_valid = 1'b0;
    @(negedge clk);
    model_req(2'd1, 1'b1, ea, ee);
    chk("hold_valid", {31'd0, o_valid}, 32'd1);
    chk("hold_action", {30'd0, o_action}, {30'd0, ea});
    chk("hold_explored", {31'd0, o_explored}, {31'd0, ee});
    hold_a = o_action; hold_e = o_explored;
    mism = 0;
    i_valid = 1'b1; i_action_predict = 2'd0; i_train_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_action !== hold_a || o_explored !== hold_e || o_valid !== 1'b1 || i_ready !== 1'b0)
        mism++;
    end
    chk("hold_stable_5", mism, 32'd0);
    i_valid = 1'b0; o_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_ready", {31'd0, i_ready}, 32'd1);
    chk("hold_release_valid", {31'd0, o_valid}, 32'd0);
    req_check("post_hold", 2'd2, 1'b1);

    // Out-of-range prediction in greedy mode
    req_check("clamp_pred3", 2'd3, 1'b0);

    // Async reset with a result pending in OUT
    eps_op(1'b1, 1'b0, 16'h1000, 16'h1000, "load_1000");
    @(negedge clk);
    i_action_predict = 2'd0; i_train_mode = 1'b0; i_valid = 1'b1; o_ready = 1'b0;
    @(posedge clk);
    @(negedge clk); i_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, o_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("async_rst_epsilon", {16'd0, o_epsilon}, 32'h0000_FFFF);
    @(negedge clk); rst_n = 1'b1; o_ready = 1'b1;
    m_lfsr = 32'hACE1_2468; m_eps = 16'hFFFF;
    req_check("after_rst_seed", 2'd0, 1'b1);

    // Reset while in DECIDE
    @(negedge clk);
    i_action_predict = 2'd1; i_train_mode = 1'b1; i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("decide_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("decide_rst_ready", {31'd0, i_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    m_lfsr = 32'hACE1_2468; m_eps = 16'hFFFF;
    req_check("decide_rst_seed", 2'd1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
